// File: rtl/cfg_streamer_pkg.sv
// Shared constants for the configuration word streamer: FSM encoding,
// sync word and word counter width.
package cfg_streamer_pkg;

  localparam int WC_W = 16;
  localparam logic [31:0] SYNC_WORD = 32'hFAB0FAB1;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_COLLECT = 3'd1;
  localparam state_t ST_SETUP   = 3'd2;
  localparam state_t ST_STROBE  = 3'd3;
  localparam state_t ST_HOLD    = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

endpackage

// File: rtl/cfg_byte_packer.sv
// Big-endian byte-to-word packer. word is the assembled value including the
// byte being accepted this cycle, zero-padded below it when in_last ends a word.
module cfg_byte_packer (
  input  logic        CLK,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        word_complete,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [31:0] acc;
  logic [31:0] merged;

  // acc only ever holds already-received bytes, so unfilled lanes stay zero
  always_comb begin
    merged = acc;
    case (idx)
      2'd0:    merged[31:24] = in_data;
      2'd1:    merged[23:16] = in_data;
      2'd2:    merged[15:8]  = in_data;
      default: merged[7:0]   = in_data;
    endcase
  end

  assign word_complete = accept & ((idx == 2'd3) | in_last);
  assign word          = merged;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idx <= 2'd0;
      acc <= 32'd0;
    end else if (clear || word_complete) begin
      idx <= 2'd0;
      acc <= 32'd0;
    end else if (accept) begin
      idx <= idx + 2'd1;
      acc <= merged;
    end
  end

endmodule

// File: rtl/cfg_word_streamer.sv
// Streams a byte bitstream into 32-bit fabric config writes with setup/hold
// framing. Optional macro CFG_STREAMER_SYNC_EN drops words until SYNC_WORD.
module cfg_word_streamer
  import cfg_streamer_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 2,
  parameter int MAX_WORDS    = 5000
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [31:0]     SelfWriteData,
  output logic            SelfWriteStrobe,
  output logic            busy,
  output logic            done,
  output logic [WC_W-1:0] word_count
);

  state_t      state;
  logic [3:0]  cnt;
  logic        end_sess;
  logic        accept;
  logic        clear;
  logic        word_complete;
  logic [31:0] word;
  logic        final_now;
  logic        take;

  assign in_ready        = (state == ST_COLLECT);
  assign SelfWriteStrobe = (state == ST_STROBE);
  assign done            = (state == ST_DONE);
  assign busy            = (state == ST_COLLECT) | (state == ST_SETUP) |
                           (state == ST_STROBE)  | (state == ST_HOLD);
  assign accept          = in_valid & in_ready;
  assign clear           = abort | (start & ((state == ST_IDLE) | (state == ST_DONE)));
  assign final_now       = end_sess | (word_count == WC_W'(MAX_WORDS - 1));

  cfg_byte_packer u_packer (
    .CLK           (CLK),
    .reset         (reset),
    .clear         (clear),
    .accept        (accept),
    .in_data       (in_data),
    .in_last       (in_last),
    .word_complete (word_complete),
    .word          (word)
  );

`ifdef CFG_STREAMER_SYNC_EN
  logic sync_found;
  assign take = sync_found | (word == SYNC_WORD);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)
      sync_found <= 1'b0;
    else if (clear)
      sync_found <= 1'b0;
    else if ((state == ST_COLLECT) && word_complete && take)
      sync_found <= 1'b1;
  end
`else
  assign take = 1'b1;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      SelfWriteData <= 32'd0;
      word_count    <= '0;
      cnt           <= 4'd0;
      end_sess      <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_COLLECT;
            word_count <= '0;
            end_sess   <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (word_complete) begin
            if (take) begin
              SelfWriteData <= word;
              end_sess      <= in_last;
              cnt           <= 4'(SETUP_CYCLES - 1);
              state         <= ST_SETUP;
            end else if (in_last) begin
              state <= ST_DONE;
            end
          end
        end
        ST_SETUP: begin
          if (cnt == 4'd0) state <= ST_STROBE;
          else             cnt   <= cnt - 4'd1;
        end
        ST_STROBE: begin
          word_count <= word_count + 1'b1;
          end_sess   <= final_now;
          if (HOLD_CYCLES == 0) begin
            state <= final_now ? ST_DONE : ST_COLLECT;
          end else begin
            cnt   <= 4'(HOLD_CYCLES - 1);
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt == 4'd0) state <= end_sess ? ST_DONE : ST_COLLECT;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_word_streamer.sv
// Randomized bench for cfg_word_streamer against a queue-based word model.
module tb_cfg_word_streamer;

  localparam int SC = 2;
  localparam int HC = 2;
  localparam int MW = 6;
  localparam logic [31:0] SYNC = 32'hFAB0FAB1;

  logic        CLK = 0;
  logic        reset = 1;
  logic        start = 0, abort = 0;
  logic [7:0]  in_data = 0;
  logic        in_valid = 0, in_last = 0;
  logic        in_ready, SelfWriteStrobe, busy, done;
  logic [31:0] SelfWriteData;
  logic [15:0] word_count;

  cfg_word_streamer #(.SETUP_CYCLES(SC), .HOLD_CYCLES(HC), .MAX_WORDS(MW)) dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe),
    .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // strobe monitor
  logic [31:0] obs_d[$];
  int          obs_t[$];
  logic [31:0] prev_d = 0;
  logic        prev_s = 0;
  int          n_wide = 0, n_unstable = 0;
  always @(negedge CLK) begin
    if (SelfWriteStrobe) begin
      obs_d.push_back(SelfWriteData);
      obs_t.push_back(cyc);
      if (prev_s) n_wide++;
      if (prev_d !== SelfWriteData) n_unstable++;
    end
    prev_s = SelfWriteStrobe;
    prev_d = SelfWriteData;
  end

  // reference model: bytes -> expected strobed words and strobe times
  logic [31:0] exp_d[$];
  int          exp_t[$];
  logic [31:0] acc;
  int          nb, exp_wc, last_wait;
  bit          synced, sess_end;
  logic [7:0]  tx_q[$];

  task automatic model_byte(input logic [7:0] b, input bit l, input int edge_n);
    logic [31:0] w;
    bit keep;
    acc = acc | ({24'd0, b} << (8 * (3 - nb)));
    nb++;
    if (nb == 4 || l) begin
      w = acc; acc = 0; nb = 0;
      keep = 1;
`ifdef CFG_STREAMER_SYNC_EN
      keep = synced || (w == SYNC);
`endif
      if (keep) begin
        synced = 1;
        exp_d.push_back(w);
        exp_t.push_back(edge_n + SC);
        exp_wc++;
        if (l || exp_wc == MW) sess_end = 1;
      end else if (l) begin
        sess_end = 1;
      end
    end
  endtask

  // called and returns at posedge+1
  task automatic push_byte(input logic [7:0] b, input bit l);
    int t = 0;
    bit got = 0;
    if (sess_end) return;
    in_data = b; in_valid = 1; in_last = l;
    while (!got && t < 40) begin
      @(negedge CLK);
      if (in_ready) got = 1; else t++;
    end
    last_wait = t;
    if (!got) chk("ready_timeout", 0, 1);
    else model_byte(b, l, cyc + 1);
    @(posedge CLK); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic send_q(input bit withlast, input int maxgap);
    for (int i = 0; i < tx_q.size(); i++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge CLK); #1; end
      push_byte(tx_q[i], withlast && (i == tx_q.size() - 1));
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) tx_q.push_back(w[8*k +: 8]);
  endtask

  task automatic start_session();
    acc = 0; nb = 0; synced = 0; exp_wc = 0; sess_end = 0;
    exp_d.delete(); exp_t.delete(); obs_d.delete(); obs_t.delete(); tx_q.delete();
    start = 1; @(posedge CLK); #1; start = 0;
  endtask

  task automatic finish_session(input string tag);
    int t = 0;
    while (!done && t < 200) begin @(negedge CLK); t++; end
    @(negedge CLK);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_wc"}, word_count, exp_wc);
    chk({tag, "_nstrobes"}, obs_d.size(), exp_d.size());
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), obs_d[i], exp_d[i]);
      chk($sformatf("%s_time%0d", tag, i), obs_t[i], exp_t[i]);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    #2;
    chk("rst_strobe", SelfWriteStrobe, 0);
    chk("rst_data", SelfWriteData, 0);
    repeat (2) @(posedge CLK);
    #1 reset = 0;
    @(negedge CLK);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wc", word_count, 0);
    @(posedge CLK); #1;

`ifndef CFG_STREAMER_SYNC_EN
    // basic word, then a two-byte tail
    start_session();
    push_word(32'h12345678);
    for (int i = 0; i < 4; i++) push_byte(tx_q[i], 0);
    chk("basic_load", SelfWriteData, 32'h12345678);
    chk("basic_nostrobe", SelfWriteStrobe, 0);
    push_byte(8'h9A, 0); push_byte(8'hBC, 1);
    finish_session("basic");

    // partial word
    start_session();
    tx_q = '{8'hAA, 8'hBB};
    send_q(1, 0);
    finish_session("partial");
    chk("partial_word", obs_d.size() > 0 ? obs_d[0] : 32'd0, 32'hAABB0000);

    // throughput with valid held
    start_session();
    push_word(32'h01020304); push_word(32'h05060708);
    for (int i = 0; i < 8; i++) begin
      push_byte(tx_q[i], i == 7);
      if (i == 4) chk("thru_ready_low", last_wait, 5);
    end
    finish_session("thru");
    if (obs_t.size() == 2) chk("thru_period", obs_t[1] - obs_t[0], 4 + SC + 1 + HC);

    // abort in SETUP of word 3
    start_session();
    for (int i = 0; i < 12; i++) push_byte(8'(i + 1), 0);
    abort = 1; @(posedge CLK); #1; abort = 0;
    @(negedge CLK);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_wc", word_count, 2);
    repeat (10) @(negedge CLK);
    chk("abort_nstrobes", obs_d.size(), 2);
    @(posedge CLK); #1;

    // async reset during the second strobe
    start_session();
    for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i), 0);
    begin
      int t = 0;
      @(negedge CLK);
      while (!(SelfWriteStrobe && word_count == 1) && t < 40) begin @(negedge CLK); t++; end
      chk("rst_find_strobe", SelfWriteStrobe, 1);
    end
    #1 reset = 1;
    #1;
    chk("arst_strobe", SelfWriteStrobe, 0);
    chk("arst_data", SelfWriteData, 0);
    chk("arst_wc", word_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", in_ready, 0);
    @(posedge CLK); #1 reset = 0;
    @(posedge CLK); #1;

    // word limit: the sixth word ends the session
    start_session();
    for (int i = 0; i < 7; i++) push_word($urandom);
    send_q(0, 1);
    finish_session("maxw");
`else
    start_session();
    push_word(32'hFFFFFFFF); push_word(32'hFAB0FAB1); push_word(32'h00000001);
    send_q(1, 1);
    finish_session("sync");
    chk("sync_wc", word_count, 2);
`endif

    // random sessions, sometimes containing the sync word
    for (int s = 0; s < 8; s++) begin
      int nw, sp, ll;
      logic [31:0] w;
      start_session();
      nw = $urandom_range(1, 5);
      sp = $urandom_range(0, nw);
      for (int i = 0; i < nw; i++) begin
        w = (i == sp) ? SYNC : $urandom;
        if (i == nw - 1) begin
          ll = $urandom_range(1, 4);
          for (int k = 0; k < ll; k++) tx_q.push_back(w[8*(3-k) +: 8]);
        end else push_word(w);
      end
      send_q(1, 2);
      finish_session($sformatf("rnd%0d", s));
    end

    chk("strobe_width", n_wide, 0);
    chk("data_stable", n_unstable, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
